// File: rtl/camera_capture.sv
// OV7670-style parallel camera front end: synchronises the camera bus into clk,
// packs four bytes per 32-bit word and emits pixel_done / frame_done strobes.
module camera_capture #(
   parameter int ROW_BYTES = 1280,
   parameter int ROWS      = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cam_pclk,
   input  logic        cam_href,
   input  logic        cam_vsync,
   input  logic [7:0]  cam_data,
   output logic [31:0] data_out,
   output logic        pixel_done,
   output logic        frame_done,
   output logic        capturing,
   output logic        line_err
);

   typedef enum logic [1:0] {
      WAIT_VS_HIGH = 2'd0,
      WAIT_VS_LOW  = 2'd1,
      CAPTURE      = 2'd2
   } state_t;

   localparam logic [10:0] ROW_BYTES_C = 11'(ROW_BYTES);
   localparam logic [8:0]  ROWS_C      = 9'(ROWS);

   logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
   logic       href_s1_q, href_s2_q, href_s3_q;
   logic       vsync_s1_q, vsync_s2_q, vsync_s3_q;
   logic [7:0] data_s1_q, data_s2_q;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [8:0]  row_cnt_q, row_cnt_d;
   logic        line_err_q, line_err_d;
   logic        capturing_q, capturing_d;
   logic        a_valid_q, a_valid_d, a_frame_q, a_frame_d;
   logic [31:0] a_word_q, a_word_d;
   logic        b_valid_q, b_valid_d, b_frame_q, b_frame_d;
   logic [31:0] b_word_q, b_word_d;
   logic [31:0] data_out_q, data_out_d;
   logic        pixel_done_q, pixel_done_d;
   logic        frame_pend_q, frame_pend_d;
   logic        frame_done_q, frame_done_d;

   logic pclk_rise, vsync_rise, vsync_fall, href_fall, accept;

   assign pclk_rise  = pclk_s2_q & ~pclk_s3_q;
   assign vsync_rise = vsync_s2_q & ~vsync_s3_q;
   assign vsync_fall = ~vsync_s2_q & vsync_s3_q;
   assign href_fall  = ~href_s2_q & href_s3_q;
   assign accept     = pclk_rise & href_s2_q & (state_q == CAPTURE);

   // Data is synchronised alongside the controls so a byte lines up with its pclk edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         {pclk_s1_q, pclk_s2_q, pclk_s3_q}    <= 3'b000;
         {href_s1_q, href_s2_q, href_s3_q}    <= 3'b000;
         {vsync_s1_q, vsync_s2_q, vsync_s3_q} <= 3'b000;
         data_s1_q <= 8'h00;
         data_s2_q <= 8'h00;
      end else begin
         {pclk_s1_q, pclk_s2_q, pclk_s3_q}    <= {cam_pclk, pclk_s1_q, pclk_s2_q};
         {href_s1_q, href_s2_q, href_s3_q}    <= {cam_href, href_s1_q, href_s2_q};
         {vsync_s1_q, vsync_s2_q, vsync_s3_q} <= {cam_vsync, vsync_s1_q, vsync_s2_q};
         data_s1_q <= cam_data;
         data_s2_q <= data_s1_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      byte_cnt_d = byte_cnt_q;
      row_cnt_d  = row_cnt_q;
      line_err_d = line_err_q;
      a_valid_d  = 1'b0;
      a_frame_d  = 1'b0;
      a_word_d   = a_word_q;
      case (state_q)
         WAIT_VS_HIGH: begin
            if (vsync_s2_q) begin
               state_d = WAIT_VS_LOW;
            end else begin
               state_d = WAIT_VS_HIGH;
            end
         end
         WAIT_VS_LOW: begin
            if (vsync_fall) begin
               state_d    = CAPTURE;
               line_err_d = 1'b0;
               idx_d      = 2'd0;
               byte_cnt_d = 11'd0;
               row_cnt_d  = 9'd0;
            end else begin
               state_d = WAIT_VS_LOW;
            end
         end
         CAPTURE: begin
            if (accept) begin
               case (idx_q)
                  2'd0:    word_d[31:24] = data_s2_q;
                  2'd1:    word_d[23:16] = data_s2_q;
                  2'd2:    word_d[15:8]  = data_s2_q;
                  default: word_d[7:0]   = data_s2_q;
               endcase
               if (idx_q == 2'd3) begin
                  a_valid_d = 1'b1;
                  a_word_d  = {word_q[31:8], data_s2_q};
               end else begin
                  a_valid_d = 1'b0;
               end
               idx_d = idx_q + 2'd1;
               if (byte_cnt_q != 11'h7FF) begin
                  byte_cnt_d = byte_cnt_q + 11'd1;
               end else begin
                  byte_cnt_d = byte_cnt_q;
               end
            end else if (href_fall) begin
               // A partial word or a wrong-length line both flag the line as bad.
               if ((idx_q != 2'd0) || (byte_cnt_q != ROW_BYTES_C)) begin
                  line_err_d = 1'b1;
               end else begin
                  line_err_d = line_err_q;
               end
               idx_d      = 2'd0;
               byte_cnt_d = 11'd0;
               if (row_cnt_q != ROWS_C) begin
                  row_cnt_d = row_cnt_q + 9'd1;
               end else begin
                  row_cnt_d = row_cnt_q;
               end
            end else begin
               idx_d = idx_q;
            end
            if (vsync_rise) begin
               state_d   = WAIT_VS_LOW;
               a_frame_d = 1'b1;
            end else begin
               state_d = CAPTURE;
            end
         end
         default: begin
            state_d = WAIT_VS_HIGH;
         end
      endcase
      capturing_d = (state_d == CAPTURE);
   end

   // frame_done trails the word pipeline by one stage so it never precedes the last word.
   always_comb begin
      b_valid_d    = a_valid_q;
      b_word_d     = a_word_q;
      b_frame_d    = a_frame_q;
      pixel_done_d = b_valid_q;
      frame_pend_d = b_frame_q;
      frame_done_d = frame_pend_q;
      if (b_valid_q) begin
         data_out_d = b_word_q;
      end else begin
         data_out_d = data_out_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_VS_HIGH;
         idx_q        <= 2'd0;
         word_q       <= 32'h0000_0000;
         byte_cnt_q   <= 11'd0;
         row_cnt_q    <= 9'd0;
         line_err_q   <= 1'b0;
         capturing_q  <= 1'b0;
         a_valid_q    <= 1'b0;
         a_frame_q    <= 1'b0;
         a_word_q     <= 32'h0000_0000;
         b_valid_q    <= 1'b0;
         b_frame_q    <= 1'b0;
         b_word_q     <= 32'h0000_0000;
         data_out_q   <= 32'h0000_0000;
         pixel_done_q <= 1'b0;
         frame_pend_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         byte_cnt_q   <= byte_cnt_d;
         row_cnt_q    <= row_cnt_d;
         line_err_q   <= line_err_d;
         capturing_q  <= capturing_d;
         a_valid_q    <= a_valid_d;
         a_frame_q    <= a_frame_d;
         a_word_q     <= a_word_d;
         b_valid_q    <= b_valid_d;
         b_frame_q    <= b_frame_d;
         b_word_q     <= b_word_d;
         data_out_q   <= data_out_d;
         pixel_done_q <= pixel_done_d;
         frame_pend_q <= frame_pend_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign data_out   = data_out_q;
   assign pixel_done = pixel_done_q;
   assign frame_done = frame_done_q;
   assign capturing  = capturing_q;
   assign line_err   = line_err_q;

endmodule
